// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch stage feeding decode. Owns the fetch PC, requests one
// word at a time from instruction memory over a req/ack handshake, and
// buffers returned words with their PCs in a small FIFO that drains to
// decode on a valid/ready handshake. A redirect flushes the buffer and
// restarts fetch at a new word-aligned address.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   imem_req     fetch request, held until acknowledged
//   imem_addr    word-aligned fetch address (the fetch PC)
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word, valid with imem_ack
//   redirect     flush buffer and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] forced to zero
//   ins_valid    head entry valid
//   ins_out      head instruction (holds last value when empty)
//   ins_pc       head PC (holds last value when empty)
//   ins_ready    decode accepts the head entry this cycle
//   occupancy    number of buffered entries
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     ins_valid,
  output logic [31:0]              ins_out,
  output logic [31:0]              ins_pc,
  input  logic                     ins_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_stateNext;
  logic [31:0]   r_fpc;
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_countNext;
  logic [31:0]   r_bufPc  [DEPTH];
  logic [31:0]   r_bufIns [DEPTH];
  logic [31:0]   r_holdPc;
  logic [31:0]   r_holdIns;
  logic          w_push;
  logic          w_pop;
  logic          w_space;

  // A returning word is only kept when it answers a live request and no
  // redirect arrives alongside it; a pop during a redirect still counts as
  // consumed, the flush simply wins over the pointer update.
  assign w_pop  = (r_count != '0) && ins_ready;
  assign w_push = (r_state == ST_REQ) && imem_ack && !redirect;

  // Count after this cycle. A new request is launched only when this leaves
  // room for the word it will bring back, so the buffer cannot overflow.
  always_comb begin
    w_countNext = r_count;
    if (redirect) begin
      w_countNext = '0;
    end else if (w_push && !w_pop) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - 1'b1;
    end
  end

  assign w_space = (w_countNext < CNT_FULL);

  // DROP keeps track of a request made stale by a redirect: its ack must
  // still be absorbed before a new request can be issued.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: w_stateNext = w_space ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (imem_ack) begin
          w_stateNext = w_space ? ST_REQ : ST_IDLE;
        end else if (redirect) begin
          w_stateNext = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          w_stateNext = w_space ? ST_REQ : ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_fpc     <= RESET_PC;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_holdPc  <= '0;
      r_holdIns <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      if (redirect) begin
        r_fpc   <= {redirect_pc[31:2], 2'b00};
        r_rdPtr <= '0;
        r_wrPtr <= '0;
      end else begin
        if (w_push) begin
          r_fpc   <= r_fpc + 32'd4;
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
      end
      // Remember whatever is on display so the outputs freeze once empty.
      if (r_count != '0) begin
        r_holdPc  <= r_bufPc[r_rdPtr];
        r_holdIns <= r_bufIns[r_rdPtr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bufPc[r_wrPtr]  <= r_fpc;
      r_bufIns[r_wrPtr] <= imem_rdata;
    end
  end

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_fpc;
  assign ins_valid = (r_count != '0);
  assign ins_out   = ins_valid ? r_bufIns[r_rdPtr] : r_holdIns;
  assign ins_pc    = ins_valid ? r_bufPc[r_rdPtr]  : r_holdPc;
  assign occupancy = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Bench for fetch_queue. A memory model answers requests after a
// configurable latency with data = addr ^ 32'hA5A5_0000. Every word the
// fetch stage should keep is pushed into a scoreboard queue when its ack is
// driven; a separate monitor compares the DUT's output side against the
// queue head each cycle and pops on accepted handshakes.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] sbq[$];
  logic [31:0] popLog[$];
  logic        memPending;
  int          memWait;
  int          memLat;
  bit          randLat;
  logic [31:0] memAddr;
  logic [31:0] expAddr;
  int          memEpoch;
  int          epoch;
  logic [31:0] modelFpc;
  logic        pushNow;
  int          readyMode;
  logic        doRedirect;
  logic [31:0] redirectTarget;
  logic [31:0] lastPc;
  logic [31:0] lastIns;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_out(ins_out), .ins_pc(ins_pc),
    .ins_ready(ins_ready), .occupancy(occupancy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus: memory model, redirect and decode readiness.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    pushNow  = 1'b0;
    if (memPending) begin
      if (memWait <= 1) begin
        imem_ack   = 1'b1;
        imem_rdata = memAddr ^ XOR_KEY;
        memPending = 1'b0;
        if (memEpoch == epoch && !doRedirect) begin
          sbq.push_back({expAddr, expAddr ^ XOR_KEY});
          pushNow  = 1'b1;
          modelFpc = expAddr + 32'd4;
        end
      end else begin
        memWait--;
        if (imem_req) checkOutput("addrStable", imem_addr, memAddr);
      end
    end else if (imem_req) begin
      checkOutput("reqAddr", imem_addr, modelFpc);
      memPending = 1'b1;
      memAddr    = imem_addr;
      expAddr    = modelFpc;
      memEpoch   = epoch;
      memWait    = randLat ? int'($urandom_range(1, 3)) : memLat;
    end
    if (doRedirect) begin
      redirect    = 1'b1;
      redirect_pc = redirectTarget;
      modelFpc    = {redirectTarget[31:2], 2'b00};
      epoch++;
      doRedirect  = 1'b0;
    end
    case (readyMode)
      0:       ins_ready = 1'b0;
      1:       ins_ready = 1'b1;
      default: ins_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstReq",   32'(imem_req),  32'd0);
    checkOutput("rstAddr",  imem_addr,      RESET_PC);
    checkOutput("rstValid", 32'(ins_valid), 32'd0);
    checkOutput("rstOut",   ins_out,        32'd0);
    checkOutput("rstPc",    ins_pc,         32'd0);
    checkOutput("rstOcc",   32'(occupancy), 32'd0);
  endtask

  // Mid-cycle asynchronous reset held across one clock edge, with a bogus
  // ack presented while reset is active.
  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs();
    memPending = 1'b0;
    sbq.delete();
    epoch++;
    modelFpc   = RESET_PC;
    pushNow    = 1'b0;
    redirect   = 1'b0;
    doRedirect = 1'b0;
    lastPc     = 32'd0;
    lastIns    = 32'd0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    rst      = 1'b1;
  endtask

  task automatic waitPops(input int n);
    int k = 0;
    while (popLog.size() < n && k < 200) begin
      applyStimulus();
      k++;
    end
    if (popLog.size() < n) checkOutput("popTimeout", popLog.size(), n);
  endtask

  task automatic waitReq(output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!imem_req && n < 50);
    if (!imem_req) checkOutput("reqTimeout", 32'(imem_req), 32'd1);
  endtask

  // Monitor: output side of the stage against the scoreboard.
  always @(negedge clk) begin
    int expCnt;
    if (rst) begin
      expCnt = sbq.size() - (pushNow ? 1 : 0);
      checkOutput("occupancy", 32'(occupancy), 32'(expCnt));
      checkOutput("insValid",  32'(ins_valid), 32'(expCnt != 0));
      if (expCnt > 0) begin
        checkOutput("insPc",  ins_pc,  sbq[0][63:32]);
        checkOutput("insOut", ins_out, sbq[0][31:0]);
        lastPc  = sbq[0][63:32];
        lastIns = sbq[0][31:0];
      end else begin
        checkOutput("holdPc",  ins_pc,  lastPc);
        checkOutput("holdOut", ins_out, lastIns);
      end
      if (occupancy == DEPTH) checkOutput("reqWhenFull", 32'(imem_req), 32'd0);
      if (ins_ready && expCnt > 0) begin
        popLog.push_back(sbq[0][63:32]);
        void'(sbq.pop_front());
      end
      if (redirect) sbq.delete();
    end
  end

  initial begin
    int n;
    imem_ack = 1'b0; imem_rdata = 32'd0; redirect = 1'b0; redirect_pc = 32'd0;
    ins_ready = 1'b1; memPending = 1'b0; memWait = 0; memLat = 1; randLat = 1'b0;
    memAddr = 32'd0; expAddr = 32'd0; memEpoch = 0; epoch = 0; modelFpc = RESET_PC;
    pushNow = 1'b0; readyMode = 1; doRedirect = 1'b0; redirectTarget = 32'd0;
    lastPc = 32'd0; lastIns = 32'd0;

    // Reset values and first-request timing
    #1 rst = 1'b0;
    #2 checkResetOutputs();
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus();
    checkOutput("firstReq",  32'(imem_req), 32'd1);
    checkOutput("firstAddr", imem_addr,     RESET_PC);
    applyStimulus();
    checkOutput("validEarly", 32'(ins_valid), 32'd0);
    applyStimulus();
    checkOutput("validAt2", 32'(ins_valid), 32'd1);
    checkOutput("firstPc",  ins_pc,         RESET_PC);
    waitPops(4);
    for (int i = 0; i < 4; i++) checkOutput("streamPc", popLog[i], 32'(4 * i));

    // Saturation with decode stalled, then drain and resume
    readyMode = 0;
    doReset();
    popLog.delete();
    repeat (30) applyStimulus();
    checkOutput("satOcc", 32'(occupancy), 32'(DEPTH));
    checkOutput("satReq", 32'(imem_req),  32'd0);
    readyMode = 1;
    waitReq(n);
    checkOutput("resumeAddr", imem_addr, 32'd16);
    waitPops(4);
    for (int i = 0; i < 4; i++) checkOutput("drainPc", popLog[i], 32'(4 * i));

    // Redirect while a request is outstanding, stale ack three cycles later
    memLat = 4;
    n = 0;
    do begin applyStimulus(); n++; end while (!(memPending && memWait == 4) && n < 50);
    doRedirect = 1'b1;
    redirectTarget = 32'h0000_0103;
    applyStimulus();
    applyStimulus();
    checkOutput("dropNoReq", 32'(imem_req),  32'd0);
    checkOutput("dropValid", 32'(ins_valid), 32'd0);
    popLog.delete();
    waitReq(n);
    checkOutput("dropReqDelay", n, 32'd3);
    checkOutput("redirAddr", imem_addr, 32'h0000_0100);
    memLat = 1;
    waitPops(1);
    checkOutput("redirFirstPc", popLog[0], 32'h0000_0100);

    // Redirect coincident with an ack and a pop from a loaded buffer
    readyMode = 0;
    memLat = 3;
    doReset();
    n = 0;
    do begin applyStimulus(); n++; end
      while (!(occupancy == 3 && memPending && memWait == 1) && n < 80);
    checkOutput("loadedOcc", 32'(occupancy), 32'd3);
    doRedirect = 1'b1;
    redirectTarget = 32'h0000_2000;
    readyMode = 1;
    memLat = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("coincOcc",   32'(occupancy), 32'd0);
    checkOutput("coincValid", 32'(ins_valid), 32'd0);
    checkOutput("coincReq",   32'(imem_req),  32'd1);
    checkOutput("coincAddr",  imem_addr,      32'h0000_2000);

    // Address wrap at the top of the space
    doRedirect = 1'b1;
    redirectTarget = 32'hFFFF_FFFC;
    applyStimulus();
    applyStimulus();
    popLog.delete();
    waitPops(2);
    checkOutput("wrapPc0", popLog[0], 32'hFFFF_FFFC);
    checkOutput("wrapPc1", popLog[1], 32'h0000_0000);

    // Reset mid-transaction with three entries buffered and a request pending
    readyMode = 0;
    doReset();
    n = 0;
    do begin applyStimulus(); n++; end while (!(occupancy == 3 && imem_req) && n < 50);
    checkOutput("midOcc", 32'(occupancy), 32'd3);
    doReset();
    applyStimulus();
    checkOutput("restartReq",  32'(imem_req), 32'd1);
    checkOutput("restartAddr", imem_addr,     RESET_PC);

    // Randomised traffic: random latency, readiness and redirects
    randLat = 1'b1;
    readyMode = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        doRedirect = 1'b1;
        redirectTarget = $urandom;
      end
      applyStimulus();
    end
    readyMode = 1;
    repeat (20) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
